hermes_buffer: RTL and testbench

Input-port flit buffer of a Hermes router, one instance per port, sitting directly upstream of the crossbar. It accepts flits from the neighbouring link under credit flow control and stores them in a circular FIFO. It raises a routing request to switch control when a packet header reaches the head. Once the connection is granted, it presents flits to the crossbar (data_av/eop/data) and pops one on each crossbar ack until the EOP flit leaves.

---
 rtl/hermes_buffer.sv | 114 +++++++++++
 tb/tb_hermes_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hermes_buffer.sv
// Hermes router input-port buffer: credit-based circular FIFO feeding the crossbar,
// with a request/grant handshake to switch control at each packet header.
module hermes_buffer #(
  parameter int unsigned FLIT_SIZE   = 32,
  parameter int unsigned BUFFER_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic                 eop_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  output logic                 req_o,
  input  logic                 ack_h_i,
  output logic                 sending_o,
  output logic                 data_av_o,
  output logic                 eop_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 ack_i
);

  localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SEND
  } state_t;

  state_t state_q, state_d;

  logic [FLIT_SIZE:0]   mem [BUFFER_SIZE];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [FLIT_SIZE:0]   head;
  logic                 push;
  logic                 pop;
  logic                 not_empty;

  assign not_empty = (count_q != '0);
  assign head      = mem[rd_ptr_q];

  assign credit_o  = (count_q != FULL_CNT);
  assign req_o     = (state_q == S_REQ);
  assign sending_o = (state_q == S_SEND);
  assign data_av_o = (state_q == S_SEND) && not_empty;
  assign eop_o     = data_av_o ? head[FLIT_SIZE] : 1'b0;
  assign data_o    = data_av_o ? head[FLIT_SIZE-1:0] : '0;

  assign push = rx_i && credit_o;
  assign pop  = data_av_o && ack_i;

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= {eop_i, data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A popped EOP closes the connection; any following packet waits for a fresh request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (not_empty) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_h_i) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (pop && head[FLIT_SIZE]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_hermes_buffer.sv
// Directed self-checking bench for hermes_buffer (FLIT_SIZE=32, BUFFER_SIZE=8).
module tb_hermes_buffer;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        eop_in;
  logic [31:0] data_in;
  logic        credit;
  logic        req;
  logic        ack_h;
  logic        sending;
  logic        data_av;
  logic        eop_out;
  logic [31:0] data_out;
  logic        ack;

  int unsigned n_checks;
  int unsigned n_fail;

  hermes_buffer #(
    .FLIT_SIZE  (32),
    .BUFFER_SIZE(8)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .rx_i     (rx),
    .eop_i    (eop_in),
    .data_i   (data_in),
    .credit_o (credit),
    .req_o    (req),
    .ack_h_i  (ack_h),
    .sending_o(sending),
    .data_av_o(data_av),
    .eop_o    (eop_out),
    .data_o   (data_out),
    .ack_i    (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    rx      = 1'b1;
    data_in = d;
    eop_in  = e;
    cyc();
    rx      = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !req; i++) cyc();
    check(tag, req, 1'b1);
  endtask

  task automatic grant();
    ack_h = 1'b1;
    cyc();
    ack_h = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_credit"}, credit, 1'b1);
    check({tag, "_req"}, req, 1'b0);
    check({tag, "_sending"}, sending, 1'b0);
    check({tag, "_data_av"}, data_av, 1'b0);
    check({tag, "_eop"}, eop_out, 1'b0);
    check({tag, "_data"}, data_out, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pk [4];
    logic [31:0] base;
    logic [5:0]  pat;
    int unsigned idx;
    int unsigned k;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rx       = 1'b0;
    eop_in   = 1'b0;
    data_in  = '0;
    ack_h    = 1'b0;
    ack      = 1'b0;

    // Reset values visible before any clock edge
    #2;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check_idle_outputs("post_reset");

    // Single packet
    pk[0] = 32'h0000_0011;
    pk[1] = 32'h0000_0002;
    pk[2] = 32'hAAAA_5555;
    pk[3] = 32'h1234_5678;
    ack = 1'b1;
    push(pk[0], 1'b0);
    check("t2_req_not_yet", req, 1'b0);
    check("t2_av_idle", data_av, 1'b0);
    push(pk[1], 1'b0);
    check("t2_req_rise", req, 1'b1);
    push(pk[2], 1'b0);
    push(pk[3], 1'b1);
    cyc();
    check("t2_req_hold", req, 1'b1);
    check("t2_av_before_grant", data_av, 1'b0);
    grant();
    for (int i = 0; i < 4; i++) begin
      check("t2_sending", sending, 1'b1);
      check("t2_av", data_av, 1'b1);
      check("t2_data", data_out, pk[i]);
      check("t2_eop", eop_out, (i == 3));
      cyc();
    end
    check_idle_outputs("t2_done");

    // Full buffer, overflow attempt, wrap (pointers start at 4)
    for (int rep = 0; rep < 2; rep++) begin
      base = 32'h100 * (rep + 1);
      for (int i = 0; i < 8; i++) begin
        check("t3_credit_open", credit, 1'b1);
        push(base + i, (i == 7));
      end
      check("t3_full", credit, 1'b0);
      rx      = 1'b1;
      data_in = 32'hDEADBEEF;
      eop_in  = 1'b1;
      cyc();
      rx = 1'b0;
      check("t3_full_hold", credit, 1'b0);
      check("t3_req", req, 1'b1);
      grant();
      for (int i = 0; i < 8; i++) begin
        if (i == 0) check("t3_credit_before_pop", credit, 1'b0);
        if (i == 1) check("t3_credit_back", credit, 1'b1);
        check("t3_av", data_av, 1'b1);
        check("t3_data", data_out, base + i);
        check("t3_eop", eop_out, (i == 7));
        cyc();
      end
      check("t3_no_extra_av", data_av, 1'b0);
      check("t3_sending_fall", sending, 1'b0);
      check("t3_req_none", req, 1'b0);
    end

    // Backpressure with a simultaneous push/pop at count=7
    ack = 1'b0;
    for (int i = 0; i < 6; i++) push(32'h200 + i, (i == 5));
    push(32'h300, 1'b0);
    check("t4_count7_credit", credit, 1'b1);
    wait_req("t4_req");
    grant();
    pat = 6'b101001;
    idx = 0;
    k   = 0;
    while (idx < 6 && k < 40) begin
      ack = pat[k % 6];
      if (k == 0) begin
        rx      = 1'b1;
        data_in = 32'h301;
        eop_in  = 1'b1;
      end
      check("t4_av", data_av, 1'b1);
      check("t4_data", data_out, 32'h200 + idx);
      check("t4_eop", eop_out, (idx == 5));
      cyc();
      rx = 1'b0;
      if (k == 0) check("t4_simul_count", credit, 1'b1);
      if (ack) idx++;
      k++;
    end
    check("t4_all_popped", idx, 6);
    check("t4_sending_fall", sending, 1'b0);
    check("t4_av_bubble", data_av, 1'b0);
    ack = 1'b1;
    cyc();
    check("t4_req_next", req, 1'b1);
    grant();
    check("t4_next_hdr", data_out, 32'h300);
    check("t4_next_hdr_eop", eop_out, 1'b0);
    cyc();
    check("t4_next_tail", data_out, 32'h301);
    check("t4_next_tail_eop", eop_out, 1'b1);
    cyc();
    check_idle_outputs("t4_done");

    // Back-to-back packets
    for (int i = 0; i < 3; i++) push(32'h400 + i, (i == 2));
    for (int i = 0; i < 3; i++) push(32'h500 + i, (i == 2));
    wait_req("t5_req");
    grant();
    for (int i = 0; i < 3; i++) begin
      check("t5_p1_data", data_out, 32'h400 + i);
      check("t5_p1_eop", eop_out, (i == 2));
      cyc();
    end
    check("t5_bubble_req", req, 1'b0);
    check("t5_bubble_send", sending, 1'b0);
    check("t5_bubble_av", data_av, 1'b0);
    cyc();
    check("t5_req_reassert", req, 1'b1);
    check("t5_no_av_in_req", data_av, 1'b0);
    grant();
    for (int i = 0; i < 3; i++) begin
      check("t5_p2_data", data_out, 32'h500 + i);
      check("t5_p2_eop", eop_out, (i == 2));
      cyc();
    end
    check_idle_outputs("t5_done");

    // Reset in the middle of a packet
    ack = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h600 + i, (i == 2));
    wait_req("t6_req");
    grant();
    check("t6_sending", sending, 1'b1);
    check("t6_head", data_out, 32'h600);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t6_av_after", data_av, 1'b0);
      check("t6_req_after", req, 1'b0);
      check("t6_credit_after", credit, 1'b1);
    end
    ack = 1'b1;
    push(32'h700, 1'b1);
    cyc();
    check("t6_req_new", req, 1'b1);
    grant();
    check("t6_new_data", data_out, 32'h700);
    check("t6_new_eop", eop_out, 1'b1);
    cyc();
    check_idle_outputs("t6_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
